// File: rtl/kernel_sequencer.sv
// kernel_sequencer: captures a short kernel of 8-bit instruction words, then executes them on an 8-bit accumulator.
// Optional build macro KSEQ_TRACE_EN adds per-execute trace outputs (trace_valid, trace_pc, trace_op).
module kernel_sequencer #(
  parameter int NUM_KERNEL = 8,
  parameter int PC_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [7:0]      number,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [7:0]      acc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W:0]   count,
  output logic            overflow
`ifdef KSEQ_TRACE_EN
  ,
  output logic            trace_valid,
  output logic [PC_W-1:0] trace_pc,
  output logic [2:0]      trace_op
`endif
);

  // state  | meaning
  // IDLE   | waiting; load restarts the kernel at word 0, start runs it
  // LOAD   | appending words to the kernel
  // RUN    | executing kernel[pc] each cycle
  // DONE   | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_SHR2 = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_LDI  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [PC_W:0] CNT_FULL = (PC_W+1)'(NUM_KERNEL);
  localparam logic [PC_W:0] CNT_ONE  = (PC_W+1)'(1);

  state_t          state, state_nxt;
  logic [7:0]      acc_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W:0]   count_nxt;
  logic            ovf_nxt;
  logic            wr_en;
  logic [PC_W-1:0] wr_addr;

  // Sized to the full pc range so pc indexes it without width adaptation;
  // only the first NUM_KERNEL entries are ever written.
  logic [7:0] kernel [2**PC_W];

  logic [7:0] cur_word;
  logic [2:0] cur_op;
  logic [7:0] cur_imm;

  assign cur_word = kernel[pc];
  assign cur_op   = cur_word[7:5];
  assign cur_imm  = {3'b000, cur_word[4:0]};

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    pc_nxt    = pc;
    count_nxt = count;
    ovf_nxt   = overflow;
    wr_en     = 1'b0;
    wr_addr   = count[PC_W-1:0];

    case (state)
      S_IDLE: begin
        if (load) begin
          wr_en     = 1'b1;
          wr_addr   = '0;
          count_nxt = CNT_ONE;
          state_nxt = S_LOAD;
        end else if (start) begin
          if (count == '0) begin
            state_nxt = S_DONE;
          end else begin
            pc_nxt    = '0;
            state_nxt = S_RUN;
          end
        end
      end

      S_LOAD: begin
        if (load) begin
          if (count == CNT_FULL) begin
            ovf_nxt = 1'b1;
          end else begin
            wr_en     = 1'b1;
            count_nxt = count + CNT_ONE;
          end
        end else if (start) begin
          pc_nxt    = '0;
          state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        case (cur_op)
          OP_SHR2: acc_nxt = acc >> 2;
          OP_ADD:  acc_nxt = acc + cur_imm;
          OP_XOR:  acc_nxt = acc ^ cur_imm;
          OP_LDI:  acc_nxt = cur_imm;
          OP_DEC:  acc_nxt = acc - 8'd1;
          default: acc_nxt = acc;
        endcase
        // HALT leaves pc on its own address; otherwise pc ends one past the last word.
        if (cur_op == OP_HALT) begin
          state_nxt = S_DONE;
        end else begin
          pc_nxt = pc + 1'b1;
          if ({1'b0, pc} == count - CNT_ONE) begin
            state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      pc       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      pc       <= pc_nxt;
      count    <= count_nxt;
      overflow <= ovf_nxt;
    end
  end

  // Kernel contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      kernel[wr_addr] <= number;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

`ifdef KSEQ_TRACE_EN
  assign trace_valid = (state == S_RUN);
  assign trace_pc    = pc;
  assign trace_op    = cur_op;
`endif

endmodule

// File: tb/tb_kernel_sequencer.sv
// Self-checking bench for kernel_sequencer: directed vector table, hand-written corner sequences,
// and randomized load/start traffic checked against a program-level reference model.
module tb_kernel_sequencer;
  localparam int NK = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [7:0]    number;
  logic          start;
  logic          busy;
  logic          done;
  logic [7:0]    acc;
  logic [PW-1:0] pc;
  logic [PW:0]   count;
  logic          overflow;

  kernel_sequencer #(.NUM_KERNEL(NK), .PC_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .number   (number),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .acc      (acc),
    .pc       (pc),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the kernel as a plain list, executed as a program.
  logic [7:0] m_kern [NK];
  int         m_count;
  int         m_pc;
  int         m_acc;
  bit         m_ovf;
  bit         m_fresh;

  task automatic m_reset();
    m_count = 0; m_pc = 0; m_acc = 0; m_ovf = 0; m_fresh = 1;
  endtask

  task automatic m_load(input logic [7:0] w);
    if (m_fresh) begin
      m_kern[0] = w; m_count = 1; m_fresh = 0;
    end else if (m_count == NK) begin
      m_ovf = 1;
    end else begin
      m_kern[m_count] = w; m_count++;
    end
  endtask

  task automatic m_run(output int cyc);
    int op;
    int imm;
    m_fresh = 1;
    if (m_count == 0) begin
      cyc = 1;
      return;
    end
    m_pc = m_count;
    cyc  = m_count + 1;
    for (int i = 0; i < m_count; i++) begin
      op  = int'(m_kern[i][7:5]);
      imm = int'(m_kern[i][4:0]);
      if (op == 7) begin
        m_pc = i;
        cyc  = i + 2;
        break;
      end
      case (op)
        1: m_acc = m_acc / 4;
        2: m_acc = (m_acc + imm) % 256;
        3: m_acc = m_acc ^ imm;
        4: m_acc = imm;
        5: m_acc = (m_acc + 255) % 256;
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0; start = 1'b0; number = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_reset();
  endtask

  task automatic load_word(input logic [7:0] w);
    load = 1'b1; number = w;
    @(negedge clk);
    load = 1'b0;
    m_load(w);
  endtask

  // Drives start at a negedge, counts clock edges until done is seen, then confirms the pulse is single-cycle.
  task automatic run_and_check(input string tag, input int exp_cyc);
    int cyc = 0;
    bit busy_bad = 0;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        cyc = c;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1;
    end
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_busy_in_run"}, {31'b0, busy_bad}, 0);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'b0, done}, 0);
  endtask

  typedef struct {
    bit          rst;
    int          n;
    logic [71:0] w;
    logic [7:0]  acc;
    int          pc;
    int          cnt;
    bit          ovf;
    int          cyc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int r;
    int k;
    logic [7:0] w;

    tbl[0] = '{1, 3, 72'h854320_000000_000000, 8'h02, 3, 3, 0, 4};
    tbl[1] = '{1, 3, 72'h9FE061_000000_000000, 8'h1F, 1, 3, 0, 3};
    tbl[2] = '{1, 2, 72'h80A0_0000000000_0000, 8'hFF, 2, 2, 0, 3};
    tbl[3] = '{0, 8, 72'h9F5F5F5F5F5F5F5F_00, 8'hF8, 8, 8, 0, 9};
    tbl[4] = '{0, 1, 72'h5F_0000000000000000, 8'h17, 1, 1, 0, 2};
    tbl[5] = '{1, 9, 72'h81_41_41_41_41_41_41_41_9F, 8'h08, 8, 8, 1, 9};
    tbl[6] = '{0, 0, 72'h0, 8'h08, 8, 8, 1, 9};

    rst_n = 1'b0; load = 1'b0; start = 1'b0; number = 8'h00;
    #1;
    check("reset_acc", {24'b0, acc}, 0);
    check("reset_pc", {28'b0, pc}, 0);
    check("reset_count", {27'b0, count}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_overflow", {31'b0, overflow}, 0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst) do_reset();
      for (int j = 0; j < tbl[i].n; j++) begin
        w = tbl[i].w[71-8*j -: 8];
        load_word(w);
      end
      check($sformatf("vec%0d_count", i), {27'b0, count}, tbl[i].cnt);
      check($sformatf("vec%0d_overflow", i), {31'b0, overflow}, {31'b0, tbl[i].ovf});
      m_run(cyc);
      run_and_check($sformatf("vec%0d", i), tbl[i].cyc);
      check($sformatf("vec%0d_acc", i), {24'b0, acc}, {24'b0, tbl[i].acc});
      check($sformatf("vec%0d_pc", i), {28'b0, pc}, tbl[i].pc);
    end

    // Reset asserted just before the second execute edge.
    do_reset();
    load_word(8'h81); load_word(8'h41); load_word(8'h41); load_word(8'h41);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrst_busy_before", {31'b0, busy}, 1);
    @(negedge clk);
    check("midrst_acc_after_first_exec", {24'b0, acc}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_acc", {24'b0, acc}, 0);
    check("midrst_pc", {28'b0, pc}, 0);
    check("midrst_count", {27'b0, count}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    begin
      bit saw_done = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (done) saw_done = 1;
      end
      check("midrst_no_done", {31'b0, saw_done}, 0);
    end
    m_reset();

    // load and start together while loading: the load wins and no run begins.
    do_reset();
    load_word(8'h81);
    load = 1'b1; start = 1'b1; number = 8'h41;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    m_load(8'h41);
    check("ldst_count", {27'b0, count}, 2);
    check("ldst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    check("ldst_busy_later", {31'b0, busy}, 0);
    check("ldst_done_later", {31'b0, done}, 0);
    m_run(cyc);
    run_and_check("ldst_run", 3);
    check("ldst_acc", {24'b0, acc}, 2);

    // start with an empty kernel goes straight to the done pulse.
    do_reset();
    m_run(cyc);
    run_and_check("empty_start", 1);
    check("empty_acc", {24'b0, acc}, 0);
    check("empty_pc", {28'b0, pc}, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 11);
      if (r == 0) begin
        do_reset();
      end else if (r <= 6) begin
        k = $urandom_range(1, 5);
        for (int j = 0; j < k; j++) begin
          w = 8'($urandom);
          load_word(w);
          if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        check("rnd_count", {27'b0, count}, m_count);
        check("rnd_overflow", {31'b0, overflow}, {31'b0, m_ovf});
      end else begin
        m_run(cyc);
        run_and_check("rnd", cyc);
        check("rnd_acc", {24'b0, acc}, m_acc);
        check("rnd_pc", {28'b0, pc}, m_pc);
        check("rnd_count_after", {27'b0, count}, m_count);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
